// File: rtl/keypad_lock_ctrl.sv
// Keypad sequencing controller: feeds digits into the PD pattern detector and
// turns its user/admin matches into unlock, admin and timed-lockout behaviour.
module keypad_lock_ctrl #(
  parameter int unsigned UNLOCK_CYCLES  = 50_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 500_000_000,
  parameter int unsigned ENTRY_TIMEOUT  = 250_000_000,
  parameter int unsigned MAX_FAILS      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       pattern1,
  input  logic       pattern2,
  output logic       det_enable,
  output logic [3:0] det_din,
  output logic       det_clear,
  output logic       unlock,
  output logic       admin,
  output logic       alarm,
  output logic [3:0] fail_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_UNLOCKED,
    ST_ADMIN,
    ST_LOCKOUT
  } state_t;

  localparam logic [31:0] ENTRY_LOAD   = 32'(ENTRY_TIMEOUT - 1);
  localparam logic [31:0] UNLOCK_LOAD  = 32'(UNLOCK_CYCLES - 1);
  localparam logic [31:0] LOCKOUT_LOAD = 32'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]  FAIL_LIMIT   = 4'(MAX_FAILS);
  localparam logic [3:0]  KEY_CLEAR    = 4'hA;
  localparam logic [3:0]  KEY_ENTER    = 4'hB;
  localparam logic [2:0]  DIGIT_MAX    = 3'd7;
  localparam logic [2:0]  CODE_LEN     = 3'd4;

  state_t      state, state_next;
  logic [31:0] timer, timer_next;
  logic [2:0]  digit_cnt, digit_cnt_next;
  logic [3:0]  fail_next;
  logic [3:0]  fail_inc;
  logic        det_enable_next;
  logic [3:0]  det_din_next;
  logic        det_clear_next;
  logic        unlock_next;
  logic        admin_next;
  logic        alarm_next;
  logic        timer_expired;
  logic        is_digit;
  logic        key_clear;
  logic        key_enter;

  assign timer_expired = (timer == 32'd0);
  assign is_digit      = (key_code <= 4'd9);
  assign key_clear     = key_valid && (key_code == KEY_CLEAR);
  assign key_enter     = key_valid && (key_code == KEY_ENTER);
  assign fail_inc      = fail_count + 4'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    state_next      = state;
    digit_cnt_next  = digit_cnt;
    fail_next       = fail_count;
    det_enable_next = 1'b0;
    det_din_next    = det_din;
    det_clear_next  = 1'b0;
    timer_next      = timer;

    case (state)
      ST_IDLE: begin
        if (key_valid && is_digit) begin
          det_enable_next = 1'b1;
          det_din_next    = key_code;
          digit_cnt_next  = 3'd1;
          state_next      = ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        if (key_valid && is_digit) begin
          det_enable_next = 1'b1;
          det_din_next    = key_code;
          if (digit_cnt != DIGIT_MAX) begin
            digit_cnt_next = digit_cnt + 3'd1;
          end
        end else if (key_clear || (!key_valid && timer_expired)) begin
          // An idle timeout discards the entry exactly like '*', without counting a failure.
          det_clear_next = 1'b1;
          digit_cnt_next = '0;
          state_next     = ST_IDLE;
        end else if (key_enter) begin
          state_next = ST_CHECK;
        end
      end

      ST_CHECK: begin
        det_clear_next = 1'b1;
        digit_cnt_next = '0;
        if ((digit_cnt == CODE_LEN) && pattern2) begin
          state_next = ST_ADMIN;
        end else if ((digit_cnt == CODE_LEN) && pattern1) begin
          state_next = ST_UNLOCKED;
        end else begin
          fail_next  = fail_inc;
          state_next = (fail_inc == FAIL_LIMIT) ? ST_LOCKOUT : ST_IDLE;
        end
      end

      ST_UNLOCKED, ST_ADMIN: begin
        if (key_clear || timer_expired) begin
          state_next = ST_IDLE;
        end
      end

      ST_LOCKOUT: begin
        if (timer_expired) begin
          fail_next  = '0;
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if ((state_next == ST_UNLOCKED) || (state_next == ST_ADMIN)) begin
      fail_next = '0;
    end

    // One shared timer: reload on state entry, reload on any key in ENTRY, else count down to 0.
    if (state_next != state) begin
      case (state_next)
        ST_ENTRY:              timer_next = ENTRY_LOAD;
        ST_UNLOCKED, ST_ADMIN: timer_next = UNLOCK_LOAD;
        ST_LOCKOUT:            timer_next = LOCKOUT_LOAD;
        default:               timer_next = '0;
      endcase
    end else if ((state == ST_ENTRY) && key_valid) begin
      timer_next = ENTRY_LOAD;
    end else if (!timer_expired) begin
      timer_next = timer - 32'd1;
    end

    unlock_next = (state_next == ST_UNLOCKED);
    admin_next  = (state_next == ST_ADMIN);
    alarm_next  = (state_next == ST_LOCKOUT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      timer      <= '0;
      digit_cnt  <= '0;
      fail_count <= '0;
      det_enable <= 1'b0;
      det_din    <= '0;
      det_clear  <= 1'b0;
      unlock     <= 1'b0;
      admin      <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state      <= state_next;
      timer      <= timer_next;
      digit_cnt  <= digit_cnt_next;
      fail_count <= fail_next;
      det_enable <= det_enable_next;
      det_din    <= det_din_next;
      det_clear  <= det_clear_next;
      unlock     <= unlock_next;
      admin      <= admin_next;
      alarm      <= alarm_next;
    end
  end

endmodule
